led_frame_scheduler: RTL and testbench
======================================

// Module: led_frame_scheduler
// PURPOSE
//  Shares one WS2812B string driver (GRB state machine + NZR bit generator) between two frame
//  sources: A = pattern generator, B = host update. Round-robin arbitration; one ShipGRB pulse
//  per granted frame. Holds NumLEDs stable for the frame. Waits for Done (last bit) then
//  allDone (>280 us latch). Enforces a minimum frame period. A watchdog recovers from a hung driver.
// PARAMETERS
//  MIN_FRAME_TICKS  1666667  min clks between successive ShipGRB pulses (60 Hz @ 100 MHz)
//  WDOG_TICKS       65535    max clks from ShipGRB to allDone before abort
// PORTS
//  clk          in   1  system clock, 100 MHz
//  reset        in   1  asynchronous, active-low reset
//  Enable       in   1  1 = grants allowed
//  ReqA         in   1  source A frame request, level
//  NumLEDsA     in   3  LED count for A's frame (1..5)
//  ReqB         in   1  source B frame request, level
//  NumLEDsB     in   3  LED count for B's frame (1..5)
//  Done         in   1  from GRB SM: last bit shipped, 1-clk pulse
//  allDone      in   1  from GRB SM: latch/reset period complete, 1-clk pulse
//  ClrErr       in   1  clears WdogErr
//  GntA         out  1  A owns the string (level, GRANT..LATCH)
//  GntB         out  1  B owns the string (level)
//  FrameDoneA   out  1  1-clk pulse: A's frame fully latched
//  FrameDoneB   out  1  1-clk pulse: B's frame fully latched
//  ShipGRB      out  1  1-clk start pulse to GRB SM
//  NumLEDs      out  3  registered LED count to GRB SM
//  Busy         out  1  state != IDLE
//  WdogErr      out  1  sticky: watchdog expired
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; all outputs 0 except NumLEDs=3'b001; LastB=1 (A wins first
//   tie); FrameCnt saturated (no HOLD owed); WdogCnt=0.
//  States: IDLE, GRANT, SHIP, LATCH, HOLD.
//  IDLE: if Enable && (ReqA||ReqB) -> GRANT. Winner: only requester; both -> the one not LastB
//   (LastB=1 -> A). Latch winner's NumLEDsx into NumLEDs (0,6,7 clamp to 3'b001). Set Gnt of winner.
//  GRANT (1 clk): ShipGRB=1. Clear FrameCnt and WdogCnt. Update LastB. -> SHIP.
//  SHIP: wait Done -> LATCH. allDone in SHIP is ignored.
//  LATCH: wait allDone -> pulse FrameDone of owner in the same clk, drop Gnt next clk -> HOLD.
//  HOLD: no grant until FrameCnt >= MIN_FRAME_TICKS-1 -> IDLE. FrameCnt (24b) counts every clk
//   from GRANT and saturates; it never wraps.
//  Latency: Req in IDLE -> Gnt set next clk; ShipGRB one clk after Gnt. Req->ShipGRB = 2 clks.
//  Watchdog: WdogCnt (16b) counts in SHIP and LATCH. At WDOG_TICKS-1: set WdogErr, drop Gnt,
//   no FrameDone, -> HOLD. ClrErr clears WdogErr; if expiry coincides with ClrErr, set wins.
//  Requester drops Req mid-frame: ignored; frame completes and FrameDone still pulses.
//  NumLEDsx changes after grant: ignored until next grant.
//  Enable=0 mid-frame: frame completes; then idle in IDLE until Enable=1.
//  Done and allDone in the same clk in SHIP: treat as Done then allDone (SHIP -> HOLD, FrameDone).
//  Gnt is one-hot or zero at all times. ShipGRB is never asserted outside GRANT.
// TESTING
//  1. ReqA=1, NumLEDsA=3, then Done at +9216 clks and allDone 28100 clks later
//     -> GntA=1 @ t+1, ShipGRB @ t+2, NumLEDs=3, FrameDoneA pulse at allDone, GntA drops next clk.
//  2. ReqA=ReqB=1 held, MIN_FRAME_TICKS=100 (sim) -> grants alternate A,B,A,B; ShipGRB pulses
//     >= 100 clks apart.
//  3. NumLEDsB=7, ReqB=1 -> NumLEDs=3'b001.
//  4. WDOG_TICKS=50, no Done -> WdogErr=1 at ShipGRB+50, GntA=0, no FrameDone; ClrErr -> 0.
//  5. Drive reset=0 mid-SHIP (async, off clock edge) -> all outputs 0 and NumLEDs=1 immediately;
//     after release, ReqB alone -> GntB.
//  6. Enable=0 during LATCH -> FrameDone still pulses; ReqA stays ungranted until Enable=1.

Source files
------------

// File: rtl/led_frame_scheduler.sv
// Round-robin scheduler sharing one WS2812B GRB/NZR driver between a pattern source (A)
// and a host source (B), with minimum frame period and a driver-hang watchdog.
module led_frame_scheduler #(
   parameter int unsigned MIN_FRAME_TICKS = 1666667,
   parameter int unsigned WDOG_TICKS      = 65535
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       Enable,
   input  logic       ReqA,
   input  logic [2:0] NumLEDsA,
   input  logic       ReqB,
   input  logic [2:0] NumLEDsB,
   input  logic       Done,
   input  logic       allDone,
   input  logic       ClrErr,
   output logic       GntA,
   output logic       GntB,
   output logic       FrameDoneA,
   output logic       FrameDoneB,
   output logic       ShipGRB,
   output logic [2:0] NumLEDs,
   output logic       Busy,
   output logic       WdogErr
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_GRANT = 3'd1,
      S_SHIP  = 3'd2,
      S_LATCH = 3'd3,
      S_HOLD  = 3'd4
   } state_t;

   localparam logic [23:0] FRAME_LAST = 24'(MIN_FRAME_TICKS - 32'd1);
   localparam logic [23:0] FRAME_SAT  = 24'hFF_FFFF;
   localparam logic [15:0] WDOG_LAST  = 16'(WDOG_TICKS - 32'd1);

   // Out-of-range LED counts fall back to a single LED so the driver never sees 0.
   function automatic logic [2:0] clamp_leds(input logic [2:0] n);
      logic [2:0] r;
      if ((n == 3'd0) || (n > 3'd5)) begin
         r = 3'd1;
      end else begin
         r = n;
      end
      return r;
   endfunction

   state_t      state_q, state_d;
   logic        gnt_a_q, gnt_a_d;
   logic        gnt_b_q, gnt_b_d;
   logic        ship_q, ship_d;
   logic [2:0]  num_leds_q, num_leds_d;
   logic        busy_q, busy_d;
   logic        wdog_err_q, wdog_err_d;
   logic        last_b_q, last_b_d;
   logic [23:0] frame_cnt_q, frame_cnt_d;
   logic [15:0] wdog_cnt_q, wdog_cnt_d;
   logic        frame_done_a_s, frame_done_b_s;
   logic        wdog_exp_s;

   // State register and all registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         gnt_a_q     <= 1'b0;
         gnt_b_q     <= 1'b0;
         ship_q      <= 1'b0;
         num_leds_q  <= 3'd1;
         busy_q      <= 1'b0;
         wdog_err_q  <= 1'b0;
         last_b_q    <= 1'b1;
         frame_cnt_q <= FRAME_SAT;
         wdog_cnt_q  <= 16'd0;
      end else begin
         state_q     <= state_d;
         gnt_a_q     <= gnt_a_d;
         gnt_b_q     <= gnt_b_d;
         ship_q      <= ship_d;
         num_leds_q  <= num_leds_d;
         busy_q      <= busy_d;
         wdog_err_q  <= wdog_err_d;
         last_b_q    <= last_b_d;
         frame_cnt_q <= frame_cnt_d;
         wdog_cnt_q  <= wdog_cnt_d;
      end
   end

   // Next-state, arbitration, counters and frame-done decode.
   always_comb begin
      state_d        = state_q;
      gnt_a_d        = gnt_a_q;
      gnt_b_d        = gnt_b_q;
      ship_d         = 1'b0;
      num_leds_d     = num_leds_q;
      last_b_d       = last_b_q;
      wdog_cnt_d     = wdog_cnt_q;
      frame_done_a_s = 1'b0;
      frame_done_b_s = 1'b0;
      wdog_exp_s     = (wdog_cnt_q == WDOG_LAST);
      if (frame_cnt_q == FRAME_SAT) begin
         frame_cnt_d = frame_cnt_q;
      end else begin
         frame_cnt_d = frame_cnt_q + 24'd1;
      end
      if (ClrErr) begin
         wdog_err_d = 1'b0;
      end else begin
         wdog_err_d = wdog_err_q;
      end

      case (state_q)
         S_IDLE: begin
            if (Enable && (ReqA || ReqB)) begin
               state_d = S_GRANT;
               // On a tie, A wins whenever B was served last.
               if (ReqA && (!ReqB || last_b_q)) begin
                  gnt_a_d    = 1'b1;
                  gnt_b_d    = 1'b0;
                  num_leds_d = clamp_leds(NumLEDsA);
               end else begin
                  gnt_a_d    = 1'b0;
                  gnt_b_d    = 1'b1;
                  num_leds_d = clamp_leds(NumLEDsB);
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_GRANT: begin
            ship_d      = 1'b1;
            frame_cnt_d = 24'd0;
            wdog_cnt_d  = 16'd0;
            last_b_d    = gnt_b_q;
            state_d     = S_SHIP;
         end
         S_SHIP: begin
            if (Done && allDone) begin
               frame_done_a_s = gnt_a_q;
               frame_done_b_s = gnt_b_q;
               gnt_a_d        = 1'b0;
               gnt_b_d        = 1'b0;
               state_d        = S_HOLD;
            end else if (Done) begin
               wdog_cnt_d = wdog_cnt_q + 16'd1;
               state_d    = S_LATCH;
            end else if (wdog_exp_s) begin
               wdog_err_d = 1'b1;
               gnt_a_d    = 1'b0;
               gnt_b_d    = 1'b0;
               state_d    = S_HOLD;
            end else begin
               wdog_cnt_d = wdog_cnt_q + 16'd1;
            end
         end
         S_LATCH: begin
            if (allDone) begin
               frame_done_a_s = gnt_a_q;
               frame_done_b_s = gnt_b_q;
               gnt_a_d        = 1'b0;
               gnt_b_d        = 1'b0;
               state_d        = S_HOLD;
            end else if (wdog_exp_s) begin
               wdog_err_d = 1'b1;
               gnt_a_d    = 1'b0;
               gnt_b_d    = 1'b0;
               state_d    = S_HOLD;
            end else begin
               wdog_cnt_d = wdog_cnt_q + 16'd1;
            end
         end
         S_HOLD: begin
            gnt_a_d = 1'b0;
            gnt_b_d = 1'b0;
            if (frame_cnt_q >= FRAME_LAST) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_HOLD;
            end
         end
         default: begin
            gnt_a_d = 1'b0;
            gnt_b_d = 1'b0;
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   assign GntA       = gnt_a_q;
   assign GntB       = gnt_b_q;
   assign ShipGRB    = ship_q;
   assign NumLEDs    = num_leds_q;
   assign Busy       = busy_q;
   assign WdogErr    = wdog_err_q;
   assign FrameDoneA = frame_done_a_s;
   assign FrameDoneB = frame_done_b_s;

endmodule

// File: tb/tb_led_frame_scheduler.sv
// Scoreboard bench for led_frame_scheduler: directed frames push expected ShipGRB,
// FrameDone and watchdog events; a negedge monitor pops and compares them.
module tb_led_frame_scheduler;

   localparam int MIN_T  = 100;
   localparam int WDOG_T = 50;
   localparam int GAP    = MIN_T + 2;
   localparam int K_SHIP = 0;
   localparam int K_DONE = 1;
   localparam int K_WERR = 2;

   logic       clk = 1'b0;
   logic       reset, Enable, ReqA, ReqB, Done, allDone, ClrErr;
   logic [2:0] NumLEDsA, NumLEDsB, NumLEDs;
   logic       GntA, GntB, FrameDoneA, FrameDoneB, ShipGRB, Busy, WdogErr;

   typedef struct {
      int kind;
      int owner;
      int nl;
      int at;
   } ev_t;

   ev_t  exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   logic werr_prev = 1'b0;

   led_frame_scheduler #(.MIN_FRAME_TICKS(MIN_T), .WDOG_TICKS(WDOG_T)) dut (
      .clk(clk), .reset(reset), .Enable(Enable),
      .ReqA(ReqA), .NumLEDsA(NumLEDsA), .ReqB(ReqB), .NumLEDsB(NumLEDsB),
      .Done(Done), .allDone(allDone), .ClrErr(ClrErr),
      .GntA(GntA), .GntB(GntB), .FrameDoneA(FrameDoneA), .FrameDoneB(FrameDoneB),
      .ShipGRB(ShipGRB), .NumLEDs(NumLEDs), .Busy(Busy), .WdogErr(WdogErr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int kind, input int owner, input int nl, input int at);
      ev_t e;
      e.kind  = kind;
      e.owner = owner;
      e.nl    = nl;
      e.at    = at;
      exp_q.push_back(e);
   endtask

   task automatic observe(input int kind, input int owner, input int nl);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event: kind %0d owner %0d nl %0d at cyc %0d, none expected",
                  kind, owner, nl, cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.owner != owner || e.nl != nl || e.at != cyc) begin
            errors++;
            $display("FAIL event: got kind %0d owner %0d nl %0d cyc %0d, expected kind %0d owner %0d nl %0d cyc %0d",
                     kind, owner, nl, cyc, e.kind, e.owner, e.nl, e.at);
         end
      end
   endtask

   // Monitor: sample on the falling edge, away from the DUT's active edge.
   always @(negedge clk) begin
      if (reset) begin
         check("gnt_onehot", int'(GntA & GntB), 0);
         if (ShipGRB)
            observe(K_SHIP, GntA ? 0 : (GntB ? 1 : 2), int'(NumLEDs));
         if (FrameDoneA) observe(K_DONE, 0, 0);
         if (FrameDoneB) observe(K_DONE, 1, 0);
         if (WdogErr && !werr_prev) observe(K_WERR, 0, 0);
      end
      werr_prev <= WdogErr;
   end

   task automatic goto_cyc(input int c);
      int guard = 0;
      while (cyc < c && guard < 5000) begin
         @(posedge clk);
         #1;
         guard++;
      end
      check("goto_cyc", cyc, c);
   endtask

   task automatic pulse_done();
      Done = 1'b1;
      @(posedge clk);
      #1;
      Done = 1'b0;
   endtask

   task automatic pulse_all();
      allDone = 1'b1;
      @(posedge clk);
      #1;
      allDone = 1'b0;
   endtask

   // Drives Done at ship+10 and allDone at ship+30, expecting FrameDone on the allDone cycle.
   task automatic run_frame(input int s, input int owner);
      goto_cyc(s + 10);
      pulse_done();
      goto_cyc(s + 30);
      push(K_DONE, owner, 0, s + 30);
      pulse_all();
      check("gnt_a_drop", int'(GntA), 0);
      check("gnt_b_drop", int'(GntB), 0);
      check("busy_hold", int'(Busy), 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int k;
      int s;
      int c;
      reset = 1'b0; Enable = 1'b1; ReqA = 1'b0; ReqB = 1'b0;
      NumLEDsA = 3'd0; NumLEDsB = 3'd0; Done = 1'b0; allDone = 1'b0; ClrErr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_gnt_a", int'(GntA), 0);
      check("rst_gnt_b", int'(GntB), 0);
      check("rst_ship", int'(ShipGRB), 0);
      check("rst_busy", int'(Busy), 0);
      check("rst_werr", int'(WdogErr), 0);
      check("rst_numleds", int'(NumLEDs), 1);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // Single A frame; request and LED count change after grant are ignored.
      k = cyc;
      NumLEDsA = 3'd3;
      ReqA = 1'b1;
      push(K_SHIP, 0, 3, k + 2);
      goto_cyc(k + 1);
      check("t1_gnt_a", int'(GntA), 1);
      check("t1_gnt_b", int'(GntB), 0);
      check("t1_busy", int'(Busy), 1);
      check("t1_ship_early", int'(ShipGRB), 0);
      ReqA = 1'b0;
      NumLEDsA = 3'd5;
      s = k + 2;
      goto_cyc(s + 5);
      check("t1_numleds_held", int'(NumLEDs), 3);
      run_frame(s, 0);

      // Both requesting: alternate B, A, B, each ship one full hold period apart.
      ReqA = 1'b1; ReqB = 1'b1; NumLEDsA = 3'd2; NumLEDsB = 3'd4;
      s = s + GAP; push(K_SHIP, 1, 4, s); run_frame(s, 1);
      s = s + GAP; push(K_SHIP, 0, 2, s); run_frame(s, 0);
      s = s + GAP; push(K_SHIP, 1, 4, s); run_frame(s, 1);

      // Out-of-range LED count clamps to 1.
      ReqA = 1'b0; NumLEDsB = 3'd7;
      s = s + GAP; push(K_SHIP, 1, 1, s); run_frame(s, 1);
      ReqB = 1'b0;

      // Watchdog: no Done after ShipGRB.
      NumLEDsA = 3'd4; ReqA = 1'b1;
      s = s + GAP;
      push(K_SHIP, 0, 4, s);
      push(K_WERR, 0, 0, s + WDOG_T);
      goto_cyc(s);
      ReqA = 1'b0;
      goto_cyc(s + WDOG_T - 1);
      check("t4_werr_before", int'(WdogErr), 0);
      check("t4_gnt_before", int'(GntA), 1);
      goto_cyc(s + WDOG_T);
      check("t4_werr_set", int'(WdogErr), 1);
      check("t4_gnt_dropped", int'(GntA), 0);
      check("t4_busy", int'(Busy), 1);
      goto_cyc(s + 55);
      ClrErr = 1'b1;
      @(posedge clk);
      #1;
      ClrErr = 1'b0;
      check("t4_werr_clr", int'(WdogErr), 0);

      // Enable dropped during LATCH: frame still completes, then no grant until re-enabled.
      NumLEDsA = 3'd5; ReqA = 1'b1;
      s = s + GAP;
      push(K_SHIP, 0, 5, s);
      goto_cyc(s + 10);
      pulse_done();
      goto_cyc(s + 15);
      Enable = 1'b0;
      goto_cyc(s + 30);
      push(K_DONE, 0, 0, s + 30);
      pulse_all();
      check("t6_gnt_drop", int'(GntA), 0);
      goto_cyc(s + 150);
      check("t6_no_grant", int'(GntA), 0);
      check("t6_idle", int'(Busy), 0);
      Enable = 1'b1;
      c = cyc;
      push(K_SHIP, 0, 5, c + 2);
      goto_cyc(c + 1);
      check("t6_regrant", int'(GntA), 1);

      // Asynchronous reset in the middle of SHIP, asserted off the clock edge.
      goto_cyc(c + 7);
      #2;
      reset = 1'b0;
      #1;
      check("t5_gnt_a", int'(GntA), 0);
      check("t5_gnt_b", int'(GntB), 0);
      check("t5_busy", int'(Busy), 0);
      check("t5_ship", int'(ShipGRB), 0);
      check("t5_numleds", int'(NumLEDs), 1);
      check("t5_werr", int'(WdogErr), 0);
      ReqA = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #3;
      reset = 1'b1;
      @(posedge clk);
      #1;
      c = cyc;
      NumLEDsB = 3'd2; ReqB = 1'b1;
      push(K_SHIP, 1, 2, c + 2);
      goto_cyc(c + 1);
      check("t5_gnt_b_after", int'(GntB), 1);
      check("t5_gnt_a_after", int'(GntA), 0);
      ReqB = 1'b0;
      run_frame(c + 2, 1);

      repeat (5) @(posedge clk);
      #1;
      check("events_outstanding", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
